// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the register-file write-back port arbiter.
package wb_arb_pkg;

  localparam int unsigned SRC_N = 3;
  localparam int unsigned SRC_W = 2;
  localparam int unsigned AGE_W = 4;

  // Encoding matches the existing write-back multiplexer select.
  typedef enum logic [SRC_W-1:0] {
    SRC_A = 2'b00,
    SRC_B = 2'b01,
    SRC_C = 2'b10
  } wb_src_e;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Base priority, slot 0 is highest: B > A > C.
  localparam logic [SRC_N*SRC_W-1:0] PRIO_ORDER = {SRC_C, SRC_A, SRC_B};

  typedef struct packed {
    logic    found;
    wb_src_e src;
  } arb_pick_t;

  // Highest base-priority source whose bit is set in mask.
  function automatic arb_pick_t prio_pick(input logic [SRC_N-1:0] mask);
    arb_pick_t p;
    wb_src_e   s;
    p.found = 1'b0;
    p.src   = SRC_A;
    for (int i = SRC_N - 1; i >= 0; i--) begin
      s = wb_src_e'(PRIO_ORDER[SRC_W*i +: SRC_W]);
      if (mask[s]) begin
        p.found = 1'b1;
        p.src   = s;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/wb_age_counter.sv
// Per-source wait counter; flags a requester that has gone WAIT_MAX cycles unserved.
module wb_age_counter
  import wb_arb_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic valid,
  input  logic accept,
  output logic aged
);

  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(WAIT_MAX);

  logic [AGE_W-1:0] cnt_q;
  logic [AGE_W-1:0] cnt_d;

  // Clear on handshake or idle, otherwise count up and saturate.
  always_comb begin
    cnt_d = cnt_q;
    if (!valid || accept) begin
      cnt_d = '0;
    end else if (cnt_q != AGE_MAX) begin
      cnt_d = cnt_q + AGE_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign aged = (cnt_q == AGE_MAX);

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates ALU / load / link results onto the single register-file write port.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned RD_W     = 5,
  parameter int unsigned WAIT_MAX = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SRC_N-1:0] req_valid,
  input  logic [RD_W-1:0]  rd_a,
  input  logic [RD_W-1:0]  rd_b,
  input  logic [RD_W-1:0]  rd_c,
  input  logic             wb_stall,
  output logic [SRC_N-1:0] req_ready,
  output logic [SRC_W-1:0] wb_sel,
  output logic             wb_we,
  output logic [RD_W-1:0]  wb_rd
);

  arb_state_e       state_q;
  arb_state_e       state_d;
  wb_src_e          lock_idx_q;
  wb_src_e          lock_idx_d;
  logic [SRC_N-1:0] aged;
  logic [SRC_N-1:0] src_accept;

  arb_pick_t        aged_pick;
  arb_pick_t        any_pick;
  wb_src_e          gnt_src;
  logic             gnt_valid;
  logic             accept;
  logic [RD_W-1:0]  gnt_rd;

  // One age tracker per source, cleared by that source's handshake.
  for (genvar g = 0; g < SRC_N; g++) begin : g_age
    wb_age_counter #(
      .WAIT_MAX (WAIT_MAX)
    ) u_age (
      .clk    (clk),
      .rst_n  (rst_n),
      .valid  (req_valid[g]),
      .accept (src_accept[g]),
      .aged   (aged[g])
    );
  end

  // Next state, grant selection and all port outputs.
  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    gnt_src    = SRC_A;
    gnt_valid  = 1'b0;
    accept     = 1'b0;
    gnt_rd     = '0;
    src_accept = '0;
    req_ready  = '0;
    wb_we      = 1'b0;
    wb_sel     = SRC_A;
    wb_rd      = '0;

    aged_pick = prio_pick(req_valid & aged);
    any_pick  = prio_pick(req_valid);

    unique case (state_q)
      IDLE: begin
        // Aged requesters outrank everyone; base priority breaks ties.
        gnt_valid = any_pick.found;
        gnt_src   = aged_pick.found ? aged_pick.src : any_pick.src;
        if (gnt_valid) begin
          if (wb_stall) begin
            state_d    = LOCKED;
            lock_idx_d = gnt_src;
          end else begin
            accept = 1'b1;
          end
        end
      end
      LOCKED: begin
        // Grant frozen until the write lands or the requester vanishes.
        gnt_src   = lock_idx_q;
        gnt_valid = req_valid[lock_idx_q];
        if (!gnt_valid) begin
          state_d = IDLE;
        end else if (!wb_stall) begin
          accept  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    unique case (gnt_src)
      SRC_A:   gnt_rd = rd_a;
      SRC_B:   gnt_rd = rd_b;
      SRC_C:   gnt_rd = rd_c;
      default: gnt_rd = '0;
    endcase

    if (accept) begin
      src_accept = SRC_N'(1) << gnt_src;
    end

    // Outputs are held at zero for the whole time reset is asserted.
    if (rst_n) begin
      wb_we     = accept;
      req_ready = src_accept;
      if (|req_valid) begin
        wb_sel = gnt_src;
        wb_rd  = gnt_rd;
      end
    end
  end

  // FSM state and locked source.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lock_idx_q <= SRC_A;
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
    end
  end

endmodule
